// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Drives the PC, IR, register-file and data-memory enables plus the datapath mux selects.
// Waits on the data-memory ready handshake and parks in HALT on an illegal opcode.
// Outputs are combinational from the state register and the live inputs, so the
// enables act in the same cycle they are decided. Holding rst low forces every
// output to zero.
module multicycle_ctrl #(
    parameter int OPC_W = 7,
    parameter int ST_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src1,
    output logic             alu_src2,
    output logic [2:0]       alu_op,
    output logic [1:0]       mem_to_reg,
    output logic             retire,
    output logic             halted,
    output logic [ST_W-1:0]  state
);

    typedef enum logic [ST_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BR    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;

    state_t state_q;
    state_t state_d;

    logic is_r_s, is_i_s, is_load_s, is_store_s, is_br_s;
    logic is_jal_s, is_jalr_s, is_lui_s, is_auipc_s, legal_s;
    logic taken_s;

    logic ir_write_s, pc_write_s, pc_sel_s, reg_write_s;
    logic mem_read_s, mem_write_s, retire_s, halted_s;
    logic alu_src1_s, alu_src2_s;
    logic [2:0] alu_op_s;
    logic [1:0] mem_to_reg_s;

    // Opcode class decode of the latched instruction.
    always_comb begin
        is_r_s     = (opcode == OPC_R);
        is_i_s     = (opcode == OPC_I);
        is_load_s  = (opcode == OPC_LOAD);
        is_store_s = (opcode == OPC_STORE);
        is_br_s    = (opcode == OPC_BR);
        is_jal_s   = (opcode == OPC_JAL);
        is_jalr_s  = (opcode == OPC_JALR);
        is_lui_s   = (opcode == OPC_LUI);
        is_auipc_s = (opcode == OPC_AUIPC);
        legal_s    = is_r_s | is_i_s | is_load_s | is_store_s | is_br_s |
                     is_jal_s | is_jalr_s | is_lui_s | is_auipc_s;
    end

    // Branch condition selected by funct3; the unused encodings are never taken.
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = br_eq;
            3'b001:  taken_s = ~br_eq;
            3'b100:  taken_s = br_lt;
            3'b110:  taken_s = br_lt;
            3'b101:  taken_s = ~br_lt;
            3'b111:  taken_s = ~br_lt;
            default: taken_s = 1'b0;
        endcase
    end

    // Datapath mux selects, held steady from decode through writeback.
    always_comb begin
        alu_src1_s   = 1'b0;
        alu_src2_s   = 1'b0;
        alu_op_s     = 3'b000;
        mem_to_reg_s = 2'b00;
        if ((state_q == S_ID) || (state_q == S_EX) ||
            (state_q == S_MEM) || (state_q == S_WB)) begin
            if (is_r_s) begin
                alu_op_s = 3'b010;
            end else if (is_i_s) begin
                alu_src2_s = 1'b1;
                alu_op_s   = 3'b011;
            end else if (is_load_s) begin
                alu_src2_s   = 1'b1;
                mem_to_reg_s = 2'b01;
            end else if (is_store_s) begin
                alu_src2_s = 1'b1;
            end else if (is_br_s) begin
                alu_src1_s = 1'b1;
                alu_src2_s = 1'b1;
                alu_op_s   = 3'b001;
            end else if (is_jal_s) begin
                alu_src1_s   = 1'b1;
                alu_src2_s   = 1'b1;
                mem_to_reg_s = 2'b10;
            end else if (is_jalr_s) begin
                alu_src2_s   = 1'b1;
                mem_to_reg_s = 2'b10;
            end else if (is_lui_s) begin
                alu_src2_s = 1'b1;
                alu_op_s   = 3'b100;
            end else if (is_auipc_s) begin
                alu_src1_s = 1'b1;
                alu_src2_s = 1'b1;
            end else begin
                alu_op_s = 3'b000;
            end
        end else begin
            alu_op_s = 3'b000;
        end
    end

    // Next-state and enable logic for the instruction sequence.
    always_comb begin
        state_d     = state_q;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_sel_s    = 1'b0;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        retire_s    = 1'b0;
        halted_s    = 1'b0;
        case (state_q)
            S_IF: begin
                // Pausing is only honoured here, at an instruction boundary.
                if (run) begin
                    ir_write_s = 1'b1;
                    state_d    = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                if (legal_s) begin
                    state_d = S_EX;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EX: begin
                if (is_load_s || is_store_s) begin
                    state_d = S_MEM;
                end else if (is_br_s) begin
                    pc_write_s = 1'b1;
                    pc_sel_s   = taken_s;
                    retire_s   = 1'b1;
                    state_d    = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Request stays up through the cycle that sees mem_ready.
                if (is_load_s) begin
                    mem_read_s = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (is_store_s) begin
                    mem_write_s = 1'b1;
                    if (mem_ready) begin
                        pc_write_s = 1'b1;
                        retire_s   = 1'b1;
                        state_d    = S_IF;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                retire_s    = 1'b1;
                pc_sel_s    = is_jal_s | is_jalr_s;
                state_d     = S_IF;
            end
            S_HALT: begin
                halted_s = 1'b1;
                state_d  = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // State register; a low rst returns the sequencer to fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Output gating: a low rst blanks every output, aborting any in-flight write.
    always_comb begin
        ir_write   = rst & ir_write_s;
        pc_write   = rst & pc_write_s;
        pc_sel     = rst & pc_sel_s;
        reg_write  = rst & reg_write_s;
        mem_read   = rst & mem_read_s;
        mem_write  = rst & mem_write_s;
        alu_src1   = rst & alu_src1_s;
        alu_src2   = rst & alu_src2_s;
        alu_op     = rst ? alu_op_s : 3'b000;
        mem_to_reg = rst ? mem_to_reg_s : 2'b00;
        retire     = rst & retire_s;
        halted     = rst & halted_s;
        state      = rst ? state_q : 3'd0;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction cycle-trace model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, br_eq, br_lt, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       ir_write, pc_write, pc_sel, reg_write, mem_read, mem_write;
    logic       alu_src1, alu_src2, retire, halted;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [2:0] state;
    logic [17:0] obs;

    int n_run  = 0;
    int n_fail = 0;

    localparam int C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5, C_JALR = 6;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BR = 7'b1100011,
                           OP_JAL = 7'b1101111;

    // Class order: R, I, LOAD, STORE, BR, JAL, JALR, LUI, AUIPC.
    logic [6:0] opc_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};
    // {alu_src1, alu_src2, alu_op, mem_to_reg}
    logic [6:0] sel_tab [9] = '{7'b0_0_010_00, 7'b0_1_011_00, 7'b0_1_000_01,
                                7'b0_1_000_00, 7'b1_1_001_00, 7'b1_1_000_10,
                                7'b0_1_000_10, 7'b0_1_100_00, 7'b1_1_000_00};

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPC_W(7), .ST_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .br_eq(br_eq), .br_lt(br_lt), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .retire(retire), .halted(halted), .state(state)
    );

    assign obs = {ir_write, pc_write, pc_sel, reg_write, mem_read, mem_write,
                  alu_src1, alu_src2, alu_op, mem_to_reg, retire, halted, state};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        for (int j = 0; j < 9; j++) if (opc_tab[j] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset;
        rst = 1'b0; run = 1'b1; opcode = OP_R; funct3 = 3'd0;
        br_eq = 1'b0; br_lt = 1'b0; mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_run++;
            if (obs !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle=%0d got %h want 0", c, obs);
            end
            tick();
        end
        rst = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_r_type;
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        run = 1'b1; opcode = OP_R;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_run++;
            if (state !== exp_st[c]) begin
                n_fail++;
                $display("FAIL r_state cycle=%0d got %0d want %0d", c, state, exp_st[c]);
            end
            if (c == 3) begin
                n_run++;
                if ({reg_write, pc_write, pc_sel, alu_op, retire} !== 7'b1_1_0_010_1) begin
                    n_fail++;
                    $display("FAIL r_wb got %b want 1101001",
                             {reg_write, pc_write, pc_sel, alu_op, retire});
                end
            end
            tick();
        end
    endtask

    task automatic test_load;
        logic [2:0] exp_st [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        int rd_cnt = 0;
        do_reset();
        run = 1'b1; opcode = OP_LOAD;
        for (int c = 0; c < 7; c++) begin
            mem_ready = (c == 5);
            @(negedge clk);
            if (mem_read === 1'b1) rd_cnt++;
            n_run++;
            if (state !== exp_st[c]) begin
                n_fail++;
                $display("FAIL load_state cycle=%0d got %0d want %0d", c, state, exp_st[c]);
            end
            if (c == 6) begin
                n_run++;
                if ({mem_to_reg, reg_write} !== 3'b01_1) begin
                    n_fail++;
                    $display("FAIL load_wb got %b want 011", {mem_to_reg, reg_write});
                end
            end
            tick();
        end
        mem_ready = 1'b0;
        n_run++;
        if (rd_cnt != 3) begin
            n_fail++;
            $display("FAIL load_read_cycles got %0d want 3", rd_cnt);
        end
    endtask

    task automatic test_branch;
        logic [2:0] f3s  [2] = '{3'b000, 3'b001};
        logic       want [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            run = 1'b1; opcode = OP_BR; funct3 = f3s[t]; br_eq = 1'b1; br_lt = 1'b0;
            tick(); tick();
            @(negedge clk);
            n_run++;
            if ({state, pc_write, pc_sel, reg_write, retire} !== {3'd2, 1'b1, want[t], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL branch_ex t=%0d got %b want %b", t,
                         {state, pc_write, pc_sel, reg_write, retire},
                         {3'd2, 1'b1, want[t], 1'b0, 1'b1});
            end
            tick();
            @(negedge clk);
            n_run++;
            if (state !== 3'd0) begin
                n_fail++;
                $display("FAIL branch_next t=%0d got %0d want 0", t, state);
            end
        end
    endtask

    task automatic test_jal_halt;
        do_reset();
        run = 1'b1; opcode = OP_JAL;
        tick(); tick(); tick();
        @(negedge clk);
        n_run++;
        if ({state, mem_to_reg, pc_sel, alu_src1, alu_src2} !== {3'd4, 2'b10, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL jal_wb got %b want 100101 11",
                     {state, mem_to_reg, pc_sel, alu_src1, alu_src2});
        end
        tick();
        opcode = 7'b1111111;
        tick();
        @(negedge clk);
        n_run++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL illegal_id got %0d want 1", state);
        end
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_run++;
            if ({halted, state, ir_write, pc_write} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL halt_hold cycle=%0d got %b want 110100", c,
                         {halted, state, ir_write, pc_write});
            end
            tick();
        end
    endtask

    task automatic test_pause;
        do_reset();
        opcode = OP_R; run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_run++;
            if ({state, ir_write} !== 4'b000_0) begin
                n_fail++;
                $display("FAIL pause cycle=%0d got %b want 0000", c, {state, ir_write});
            end
            tick();
        end
        run = 1'b1;
        @(negedge clk);
        n_run++;
        if ({state, ir_write} !== 4'b000_1) begin
            n_fail++;
            $display("FAIL pause_release got %b want 0001", {state, ir_write});
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_store_reset;
        do_reset();
        run = 1'b1; opcode = OP_STORE; mem_ready = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        n_run++;
        if ({state, mem_write} !== 4'b011_1) begin
            n_fail++;
            $display("FAIL store_mem got %b want 0111", {state, mem_write});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_run++;
        if ({state, mem_write, pc_write, retire} !== 6'd0) begin
            n_fail++;
            $display("FAIL store_abort got %b want 000000", {state, mem_write, pc_write, retire});
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if ({state, ir_write} !== 4'b000_1) begin
            n_fail++;
            $display("FAIL store_refetch got %b want 0001", {state, ir_write});
        end
        tick(); tick(); tick();
        mem_ready = 1'b1;
        @(negedge clk);
        n_run++;
        if ({state, mem_write, pc_write, pc_sel, retire} !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL store_done got %b want 0111101", {state, mem_write, pc_write, pc_sel, retire});
        end
        tick();
        mem_ready = 1'b0;
    endtask

    // Each instruction expands into an expected list of states built from the
    // class latency rules; every cycle of the list fixes every output.
    task automatic test_random;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int cls, a, b, w, npause, mem_idx;
            bit illegal, taken, last;
            logic [6:0] opc;
            logic [2:0] f3;
            logic [2:0] path [$];
            logic [6:0] sel;
            logic [17:0] exp_v;

            illegal = ($urandom_range(0, 9) == 0);
            cls     = $urandom_range(0, 8);
            opc     = opc_tab[cls];
            if (illegal) begin
                opc = 7'($urandom_range(0, 127));
                while (is_legal(opc)) opc = 7'($urandom_range(0, 127));
            end
            f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            w = $urandom_range(0, 3);
            npause = $urandom_range(0, 2);
            case (f3)
                3'd0:       taken = (a == b);
                3'd1:       taken = (a != b);
                3'd4, 3'd6: taken = (a < b);
                3'd5, 3'd7: taken = (a >= b);
                default:    taken = 1'b0;
            endcase
            opcode = opc; funct3 = f3; br_eq = (a == b); br_lt = (a < b);

            for (int p = 0; p < npause; p++) begin
                run = 1'b0; mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n_run++;
                if (obs !== 18'd0) begin
                    n_fail++;
                    $display("FAIL rnd_pause i=%0d got %h want 0", i, obs);
                end
                tick();
            end

            path.delete();
            path.push_back(3'd0);
            path.push_back(3'd1);
            if (illegal) begin
                repeat (3) path.push_back(3'd5);
            end else begin
                path.push_back(3'd2);
                if (cls == C_LOAD || cls == C_STORE) repeat (w + 1) path.push_back(3'd3);
                if (cls != C_BR && cls != C_STORE) path.push_back(3'd4);
            end

            mem_idx = 0;
            for (int k = 0; k < path.size(); k++) begin
                run = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (path[k] == 3'd3) begin
                    mem_ready = (mem_idx == w);
                    mem_idx++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                last = !illegal && (k == path.size() - 1);
                sel  = (!illegal && k > 0 && path[k] != 3'd5) ? sel_tab[cls] : 7'd0;
                exp_v = {(k == 0),
                         last,
                         last && ((cls == C_BR && taken) || cls == C_JAL || cls == C_JALR),
                         last && cls != C_BR && cls != C_STORE,
                         !illegal && path[k] == 3'd3 && cls == C_LOAD,
                         !illegal && path[k] == 3'd3 && cls == C_STORE,
                         sel,
                         last,
                         (path[k] == 3'd5),
                         path[k]};
                @(negedge clk);
                n_run++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_cycle i=%0d opc=%b k=%0d got %h want %h", i, opc, k, obs, exp_v);
                end
                tick();
            end
            if (illegal) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_branch();
        test_jal_halt();
        test_pause();
        test_store_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog run did not complete, %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1);
    end

endmodule
